// File: rtl/div_complex_pkg.sv
// Shared definitions for the iterative complex divider: FSM encoding and the
// width helpers used to size the numerator and denominator datapaths.
package div_complex_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MULT = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

    // NUM_W: one extra bit because num is a sum/difference of two full-width products.
    function automatic int num_w(input int data_size);
        return 2 * data_size + 1;
    endfunction

    function automatic int den_w(input int data_size);
        return 2 * data_size;
    endfunction

endpackage

// File: rtl/div_restoring_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder and subtract the denominator when it fits.
module div_restoring_step #(
    parameter int DEN_W = 32
) (
    input  logic [DEN_W-1:0] den,
    input  logic [DEN_W-1:0] rem,
    input  logic             bit_in,
    output logic [DEN_W-1:0] rem_next,
    output logic             q_bit
);

    logic [DEN_W:0] trial;

    assign trial    = {rem, bit_in};
    assign q_bit    = (trial >= {1'b0, den});
    // The remainder stays below den, so the restored/subtracted value fits DEN_W bits.
    assign rem_next = DEN_W'(q_bit ? (trial - {1'b0, den}) : trial);

endmodule

// File: rtl/div_complex_iter.sv
// Iterative complex divider a/b = a*conj(b)/|b|^2 with a shared-denominator
// restoring divider producing one quotient bit per cycle for I and Q.
module div_complex_iter
    import div_complex_pkg::*;
#(
    parameter int DATA_SIZE = 16,
    parameter int FRAC_BITS = 0
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic [DATA_SIZE-1:0] i_data_a_i,
    input  logic [DATA_SIZE-1:0] i_data_a_q,
    input  logic [DATA_SIZE-1:0] i_data_b_i,
    input  logic [DATA_SIZE-1:0] i_data_b_q,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [DATA_SIZE-1:0] o_data_i,
    output logic [DATA_SIZE-1:0] o_data_q,
    output logic                 o_dbz,
    output logic                 o_sat
);

    localparam int NUM_W = num_w(DATA_SIZE);
    localparam int DEN_W = den_w(DATA_SIZE);
    localparam int N_W   = DEN_W + FRAC_BITS;   // |num| scaled by 2^FRAC_BITS
    localparam int CMP_W = N_W + DATA_SIZE;     // room for den * (2^(DATA_SIZE-1) + 1)
    localparam int CNT_W = $clog2(DATA_SIZE + 1);
    localparam logic [CNT_W-1:0]     LAST    = CNT_W'(DATA_SIZE - 1);
    localparam logic [DATA_SIZE-1:0] SAT_MAX = {1'b0, {(DATA_SIZE-1){1'b1}}};
    localparam logic [DATA_SIZE-1:0] SAT_MIN = {1'b1, {(DATA_SIZE-1){1'b0}}};

    state_t state, state_next;

    logic signed [DATA_SIZE-1:0] a_i_r, a_q_r, b_i_r, b_q_r;
    logic signed [DEN_W-1:0]     p_aibi, p_aqbq, p_aqbi, p_aibq, p_bibi, p_bqbq;
    logic signed [NUM_W-1:0]     num_i, num_q;
    logic [NUM_W-1:0]            abs_i, abs_q;
    logic [DEN_W-1:0]            den;
    logic [N_W-1:0]              n_i, n_q;
    logic [CMP_W-1:0]            lim_pos, lim_neg;
    logic                        neg_i_c, neg_q_c, ovf_i_c, ovf_q_c;

    logic [DEN_W-1:0]     den_r, rem_i_r, rem_q_r, rem_i_nx, rem_q_nx;
    logic [DATA_SIZE-1:0] sh_i_r, sh_q_r, sh_i_nx, sh_q_nx;
    logic                 qb_i, qb_q;
    logic                 neg_i_r, neg_q_r, ovf_i_r, ovf_q_r, dbz_r;
    logic [CNT_W-1:0]     cnt_r;
    logic [DATA_SIZE-1:0] res_i, res_q;

    // Products and conjugate-multiply terms, evaluated from the captured operands in MULT.
    assign p_aibi = DEN_W'(a_i_r) * DEN_W'(b_i_r);
    assign p_aqbq = DEN_W'(a_q_r) * DEN_W'(b_q_r);
    assign p_aqbi = DEN_W'(a_q_r) * DEN_W'(b_i_r);
    assign p_aibq = DEN_W'(a_i_r) * DEN_W'(b_q_r);
    assign p_bibi = DEN_W'(b_i_r) * DEN_W'(b_i_r);
    assign p_bqbq = DEN_W'(b_q_r) * DEN_W'(b_q_r);

    assign num_i = NUM_W'(p_aibi) + NUM_W'(p_aqbq);
    assign num_q = NUM_W'(p_aqbi) - NUM_W'(p_aibq);
    assign den   = $unsigned(p_bibi) + $unsigned(p_bqbq);

    assign neg_i_c = num_i[NUM_W-1];
    assign neg_q_c = num_q[NUM_W-1];
    assign abs_i   = neg_i_c ? -num_i : num_i;
    assign abs_q   = neg_q_c ? -num_q : num_q;
    assign n_i     = N_W'(abs_i) << FRAC_BITS;
    assign n_q     = N_W'(abs_q) << FRAC_BITS;

    // A negative result may reach exactly -2^(DATA_SIZE-1), hence the extra den.
    assign lim_pos = CMP_W'(den) << (DATA_SIZE - 1);
    assign lim_neg = lim_pos + CMP_W'(den);
    assign ovf_i_c = (CMP_W'(n_i) >= (neg_i_c ? lim_neg : lim_pos));
    assign ovf_q_c = (CMP_W'(n_q) >= (neg_q_c ? lim_neg : lim_pos));

    div_restoring_step #(.DEN_W(DEN_W)) u_step_i (
        .den      (den_r),
        .rem      (rem_i_r),
        .bit_in   (sh_i_r[DATA_SIZE-1]),
        .rem_next (rem_i_nx),
        .q_bit    (qb_i)
    );

    div_restoring_step #(.DEN_W(DEN_W)) u_step_q (
        .den      (den_r),
        .rem      (rem_q_r),
        .bit_in   (sh_q_r[DATA_SIZE-1]),
        .rem_next (rem_q_nx),
        .q_bit    (qb_q)
    );

    // Dividend low bits shift out of the top while quotient bits shift in at the bottom.
    assign sh_i_nx = {sh_i_r[DATA_SIZE-2:0], qb_i};
    assign sh_q_nx = {sh_q_r[DATA_SIZE-2:0], qb_q};

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_reset) state <= IDLE;
        else         state <= state_next;
    end

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        state_next = state;
        o_ready    = 1'b0;
        o_valid    = 1'b0;
        case (state)
            IDLE: begin
                o_ready = 1'b1;
                if (i_valid) state_next = MULT;
            end
            MULT: state_next = DIV;
            DIV:  if (cnt_r == LAST) state_next = DONE;
            DONE: begin
                o_valid = 1'b1;
                if (i_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: datapath registers carry no reset; the FSM never consumes them before they are loaded.
    always_ff @(posedge i_clk) begin
        case (state)
            IDLE: begin
                if (i_valid) begin
                    a_i_r <= i_data_a_i;
                    a_q_r <= i_data_a_q;
                    b_i_r <= i_data_b_i;
                    b_q_r <= i_data_b_q;
                end
            end
            MULT: begin
                den_r   <= den;
                dbz_r   <= (den == '0);
                neg_i_r <= neg_i_c;
                neg_q_r <= neg_q_c;
                ovf_i_r <= ovf_i_c;
                ovf_q_r <= ovf_q_c;
                rem_i_r <= DEN_W'(n_i >> DATA_SIZE);
                rem_q_r <= DEN_W'(n_q >> DATA_SIZE);
                sh_i_r  <= n_i[DATA_SIZE-1:0];
                sh_q_r  <= n_q[DATA_SIZE-1:0];
                cnt_r   <= '0;
            end
            DIV: begin
                rem_i_r <= rem_i_nx;
                rem_q_r <= rem_q_nx;
                sh_i_r  <= sh_i_nx;
                sh_q_r  <= sh_q_nx;
                cnt_r   <= cnt_r + CNT_W'(1);
            end
            default: ;
        endcase
    end

    always_comb begin
        res_i = '0;
        res_q = '0;
        if (!dbz_r) begin
            if (ovf_i_r) res_i = neg_i_r ? SAT_MIN : SAT_MAX;
            else         res_i = neg_i_r ? -sh_i_nx : sh_i_nx;
            if (ovf_q_r) res_q = neg_q_r ? SAT_MIN : SAT_MAX;
            else         res_q = neg_q_r ? -sh_q_nx : sh_q_nx;
        end
    end

    // Results load on the final DIV step and then hold until the next operation finishes.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_data_i <= '0;
            o_data_q <= '0;
            o_dbz    <= 1'b0;
            o_sat    <= 1'b0;
        end else if (state == DIV && cnt_r == LAST) begin
            o_data_i <= res_i;
            o_data_q <= res_q;
            o_dbz    <= dbz_r;
            o_sat    <= !dbz_r && (ovf_i_r || ovf_q_r);
        end
    end

endmodule

// File: tb/tb_div_complex_iter.sv
// Directed bench for div_complex_iter (DATA_SIZE=16, FRAC_BITS=8): hand-computed
// quotients, saturation/divide-by-zero, backpressure, throughput and mid-op reset.
module tb_div_complex_iter;

    localparam int DS = 16;

    logic          i_clk = 1'b0;
    logic          i_reset, i_valid, i_ready;
    logic          o_ready, o_valid, o_dbz, o_sat;
    logic [DS-1:0] i_data_a_i, i_data_a_q, i_data_b_i, i_data_b_q;
    logic [DS-1:0] o_data_i, o_data_q;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    div_complex_iter #(.DATA_SIZE(DS), .FRAC_BITS(8)) dut (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_valid    (i_valid),
        .o_ready    (o_ready),
        .i_data_a_i (i_data_a_i),
        .i_data_a_q (i_data_a_q),
        .i_data_b_i (i_data_b_i),
        .i_data_b_q (i_data_b_q),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_data_i   (o_data_i),
        .o_data_q   (o_data_q),
        .o_dbz      (o_dbz),
        .o_sat      (o_sat)
    );

    always #5 i_clk = ~i_clk;
    always @(posedge i_clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Starts just after a rising edge with the DUT idle; returns at a falling edge
    // with the number of edges from the accept cycle to the first o_valid.
    task automatic issue(input int ai, input int aq, input int bi, input int bq,
                         output int lat);
        i_data_a_i = DS'(ai);
        i_data_a_q = DS'(aq);
        i_data_b_i = DS'(bi);
        i_data_b_q = DS'(bq);
        i_valid    = 1'b1;
        lat        = 0;
        do begin
            @(posedge i_clk);
            lat++;
            #1 i_valid = 1'b0;
            @(negedge i_clk);
        end while (!o_valid && lat < 40);
    endtask

    task automatic consume();
        i_ready = 1'b1;
        @(posedge i_clk);
        #1 i_ready = 1'b0;
    endtask

    task automatic run_op(input int ai, input int aq, input int bi, input int bq,
                          input int ei, input int eq, input int edbz, input int esat,
                          input string tag);
        int lat;
        issue(ai, aq, bi, bq, lat);
        check({tag, "_lat"}, lat, 18);
        check({tag, "_i"},   32'($signed(o_data_i)), ei);
        check({tag, "_q"},   32'($signed(o_data_q)), eq);
        check({tag, "_dbz"}, 32'(o_dbz), edbz);
        check({tag, "_sat"}, 32'(o_sat), esat);
        consume();
    endtask

    initial begin
        int lat;
        int n_acc;
        int acc[3];
        bit seen;

        i_reset = 1'b1; i_valid = 1'b0; i_ready = 1'b0;
        i_data_a_i = '0; i_data_a_q = '0; i_data_b_i = '0; i_data_b_q = '0;
        repeat (3) @(posedge i_clk);
        #1 i_reset = 1'b0;
        @(negedge i_clk);
        check("rst_ready", 32'(o_ready), 1);
        check("rst_valid", 32'(o_valid), 0);
        check("rst_i",     32'($signed(o_data_i)), 0);
        check("rst_q",     32'($signed(o_data_q)), 0);
        check("rst_dbz",   32'(o_dbz), 0);
        check("rst_sat",   32'(o_sat), 0);
        @(posedge i_clk); #1;

        run_op(256, 0, 256, 0,       256, 0, 0, 0,         "unit");
        run_op(256, 256, 0, 256,     256, -256, 0, 0,      "rot");
        run_op(-512, 0, 256, 0,      -512, 0, 0, 0,        "neg");
        run_op(32767, 0, 1, 0,       32767, 0, 0, 1,       "satpos");
        run_op(-32768, 0, 1, 0,      -32768, 0, 0, 1,      "satneg");
        run_op(100, -100, 0, 0,      0, 0, 1, 0,           "dbz");
        run_op(1000, 300, 300, -400, 184, 501, 0, 0,       "trunc");
        run_op(-7, 0, 3, 0,          -597, 0, 0, 0,        "truncneg");
        run_op(5, 0, 0, 3,           0, -426, 0, 0,        "qneg");
        run_op(128, 0, 1, 0,         32767, 0, 0, 1,       "edgepos");
        run_op(-128, 0, 1, 0,        -32768, 0, 0, 0,      "edgeneg");
        run_op(127, 0, 1, 0,         32512, 0, 0, 0,       "underpos");

        // Backpressure: DONE holds with i_ready low, stray i_valid ignored.
        issue(256, 256, 0, 256, lat);
        check("bp_lat", lat, 18);
        i_valid = 1'b1;
        i_data_a_i = DS'(1); i_data_a_q = DS'(1); i_data_b_i = DS'(1); i_data_b_q = DS'(1);
        for (int k = 0; k < 10; k++) begin
            check("bp_valid", 32'(o_valid), 1);
            check("bp_ready", 32'(o_ready), 0);
            check("bp_i",     32'($signed(o_data_i)), 256);
            check("bp_q",     32'($signed(o_data_q)), -256);
            @(posedge i_clk);
            @(negedge i_clk);
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        @(posedge i_clk);
        #1 i_ready = 1'b0;
        @(negedge i_clk);
        check("bp_release_ready", 32'(o_ready), 1);
        check("bp_release_valid", 32'(o_valid), 0);
        @(posedge i_clk); #1;

        // Back-to-back: i_valid and i_ready held high, accepts every 19 cycles.
        i_data_a_i = DS'(256); i_data_a_q = '0; i_data_b_i = DS'(256); i_data_b_q = '0;
        i_valid = 1'b1;
        i_ready = 1'b1;
        n_acc   = 0;
        acc     = '{0, 0, 0};
        for (int k = 0; k < 80 && n_acc < 3; k++) begin
            @(negedge i_clk);
            if (o_ready) begin
                acc[n_acc] = cyc;
                n_acc++;
            end
        end
        i_valid = 1'b0;
        i_ready = 1'b0;
        check("b2b_count", n_acc, 3);
        check("b2b_gap0",  acc[1] - acc[0], 19);
        check("b2b_gap1",  acc[2] - acc[1], 19);
        @(posedge i_clk); #1;

        // Reset during DIV cycle 5 aborts the operation.
        i_data_a_i = DS'(256); i_data_a_q = DS'(256); i_data_b_i = '0; i_data_b_q = DS'(256);
        i_valid = 1'b1;
        @(posedge i_clk);
        #1 i_valid = 1'b0;
        repeat (5) @(posedge i_clk);
        #1 i_reset = 1'b1;
        @(posedge i_clk);
        #1 i_reset = 1'b0;
        @(negedge i_clk);
        check("abort_ready", 32'(o_ready), 1);
        check("abort_valid", 32'(o_valid), 0);
        check("abort_i",     32'($signed(o_data_i)), 0);
        check("abort_sat",   32'(o_sat), 0);
        seen = 1'b0;
        repeat (30) begin
            @(negedge i_clk);
            if (o_valid) seen = 1'b1;
        end
        check("abort_no_valid", 32'(seen), 0);
        @(posedge i_clk); #1;
        run_op(-7, 0, 3, 0, -597, 0, 0, 0, "post_reset");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
